// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-side run controller and its driver.
// Breakpoint signals exist only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run_sw;
    logic             step_btn;
    logic             cpu_rst_req;
    logic             cpu_halt;
    logic             cpu_ce;
    logic             cpu_rst;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       state;
    logic             halted;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic             bp_en;
    logic [31:0]      bp_pc;
    logic [31:0]      cpu_pc;

    modport master (
        output run_sw, step_btn, cpu_rst_req, cpu_halt, bp_en, bp_pc, cpu_pc,
        input  cpu_ce, cpu_rst, cycle_cnt, state, halted
    );
    modport slave (
        input  run_sw, step_btn, cpu_rst_req, cpu_halt, bp_en, bp_pc, cpu_pc,
        output cpu_ce, cpu_rst, cycle_cnt, state, halted
    );
`else
    modport master (
        output run_sw, step_btn, cpu_rst_req, cpu_halt,
        input  cpu_ce, cpu_rst, cycle_cnt, state, halted
    );
    modport slave (
        input  run_sw, step_btn, cpu_rst_req, cpu_halt,
        output cpu_ce, cpu_rst, cycle_cnt, state, halted
    );
`endif
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing a one-cycle CPU clock-enable and held CPU reset; all outputs
// registered (1-cycle latency), no backpressure. Breakpoint logic under CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int TICK_DIV = 3_125_000,
    parameter int DEBOUNCE = 16,
    parameter int RST_HOLD = 4,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_PAUSE = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_ce_q, cpu_ce_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_lvl_q, db_lvl_d;
    logic              step_evt;
    logic              bp_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            cpu_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= HOLD_INIT;
            tick_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            db_lvl_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_ce_q  <= cpu_ce_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            tick_q    <= tick_d;
            sync1_q   <= bus.step_btn;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
        end
    end

    // Debounce: a differing synced level must persist DEBOUNCE cycles; only presses raise step_evt.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        step_evt = 1'b0;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = sync2_q;
                step_evt = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;

    // The first pulse after entering RUN executes even at a matching PC.
    assign bp_hit = bus.bp_en && (bus.cpu_pc == bus.bp_pc) && !bp_skip_q;

    always_comb begin
        bp_skip_d = bp_skip_q;
        if (state_q != S_RUN && state_d == S_RUN) begin
            bp_skip_d = 1'b1;
        end else if (state_q == S_RUN && cpu_ce_d) begin
            bp_skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_skip_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cpu_rst_d = 1'b0;
        cpu_ce_d  = 1'b0;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        tick_d    = '0;
        unique case (state_q)
            S_RST: begin
                cpu_rst_d = 1'b1;
                cnt_d     = '0;
                hold_d    = hold_q - HOLD_W'(1);
                // Leaving on the final decrement so cpu_rst lasts exactly RST_HOLD cycles.
                if (hold_q <= HOLD_W'(1)) begin
                    state_d   = bus.run_sw ? S_RUN : S_PAUSE;
                    cpu_rst_d = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.cpu_halt) begin
                    state_d = S_HALT;
                end else if (bp_hit || !bus.run_sw) begin
                    state_d = S_PAUSE;
                end else if (tick_q == TICK_LAST) begin
                    cpu_ce_d = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_PAUSE: begin
                if (bus.cpu_halt) begin
                    state_d = S_HALT;
                end else begin
                    cpu_ce_d = step_evt;
                    if (bus.run_sw) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (bus.cpu_rst_req) begin
            state_d   = S_RST;
            hold_d    = HOLD_INIT;
            cpu_rst_d = 1'b1;
            cpu_ce_d  = 1'b0;
            cnt_d     = '0;
        end

        if (cpu_ce_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        halted_d = (state_d == S_HALT);
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;

endmodule
